// File: rtl/uart_top.sv
// UART transmitter/receiver pair on one clock: 8N1 framing, LSB first, line idles high.
// Optional feature: define UART_PARITY_EN for an even parity bit between data and stop.
module uart_top #(
  parameter int CLK_FREQ  = 1_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] txin_i,
  output logic       tx_o,
  input  logic       rx_i,
  output logic [7:0] rxout_o,
  output logic       rxdone_o,
  output logic       txdone_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, TX_DONE
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_q, tx_d;
  logic            txdone_q, txdone_d;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rxout_q, rxout_d;
  logic            rxdone_q, rxdone_d;
  logic            rx_meta_q, rx_sync_q;
  logic            rx_par_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= 3'd0;
      tx_data_q  <= 8'h00;
      tx_q       <= 1'b1;
      txdone_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_data_q  <= tx_data_d;
      tx_q       <= tx_d;
      txdone_q   <= txdone_d;
    end
  end

  // tx_d is the line level for the state being entered, so tx_o is glitch-free and registered
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_data_d  = tx_data_q;
    tx_d       = tx_q;
    txdone_d   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d     = 1'b1;
        tx_cnt_d = '0;
        if (start_i) begin
          tx_data_d  = txin_i;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = 3'd0;
          tx_d       = tx_data_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_d       = ^tx_data_q;
            tx_state_d = TX_PAR;
`else
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            tx_d     = tx_data_q[tx_idx_d];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_PAR: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          txdone_d   = 1'b1;
          tx_state_d = TX_DONE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DONE: begin
        tx_d       = 1'b1;
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
      default: begin
        tx_d       = 1'b1;
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

`ifdef UART_PARITY_EN
  logic rx_perr_q, rx_perr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_perr_q <= 1'b0;
    end else begin
      rx_perr_q <= rx_perr_d;
    end
  end

  // Parity error is latched and the frame is dropped only at the stop bit, keeping RX in step with the line
  always_comb begin
    rx_perr_d = rx_perr_q;
    if (rx_state_q == RX_PAR && rx_cnt_q == BIT_LAST) begin
      rx_perr_d = rx_sync_q ^ (^rx_shift_q);
    end else begin
      rx_perr_d = rx_perr_q;
    end
  end

  assign rx_par_ok = ~rx_perr_q;
`else
  assign rx_par_ok = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rxout_q    <= 8'h00;
      rxdone_q   <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rxout_q    <= rxout_d;
      rxdone_q   <= rxdone_d;
    end
  end

  // Half-bit wait after the falling edge aligns all later samples to bit centres
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rxout_d    = rxout_q;
    rxdone_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PAR;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_PAR: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q && rx_par_ok) begin
            rxout_d  = rx_shift_q;
            rxdone_d = 1'b1;
          end else begin
            rxdone_d = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  assign tx_o     = tx_q;
  assign txdone_o = txdone_q;
  assign rxout_o  = rxout_q;
  assign rxdone_o = rxdone_q;

endmodule

// File: tb/tb_uart_top.sv
// Directed self-checking bench for uart_top at default parameters (104 clocks per bit).
// Build with UART_PARITY_EN defined to exercise the 11-bit frame.
module tb_uart_top;

  localparam int C = 104;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // tx falls at edge 0; RX detects the start 3 edges later, centres after 52 more, then samples every C
  localparam int RX_LAT = 55 + (FRAME_BITS - 1) * C;
  localparam int TX_LAT = FRAME_BITS * C;

  logic       clk = 1'b0;
  logic       rst, start, rx_drv, loop_en;
  logic [7:0] txin;
  logic       tx, rxdone, txdone, rx_w;
  logic [7:0] rxout;

  int total = 0;
  int bad = 0;
  int rx_pulses = 0;
  logic [7:0] rnd [10];

  assign rx_w = loop_en ? tx : rx_drv;

  uart_top dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .txin_i   (txin),
    .tx_o     (tx),
    .rx_i     (rx_w),
    .rxout_o  (rxout),
    .rxdone_o (rxdone),
    .txdone_o (txdone)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rxdone) rx_pulses <= rx_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_pulse(input bit want_rx, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(want_rx ? rxdone : txdone) && cyc < budget);
    if (!(want_rx ? rxdone : txdone)) check_eq(want_rx ? "rx_timeout" : "tx_timeout", 32'd0, 32'd1);
  endtask

  // bits go out LSB first, C cycles each, the last one held last_len cycles, then idle high
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int last_len);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = bits[i];
      repeat ((i == nbits - 1) ? last_len : C) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * C) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic stop_v);
`ifdef UART_PARITY_EN
    return {stop_v, ^d, d, 1'b0};
`else
    return {1'b0, stop_v, d, 1'b0};
`endif
  endfunction

  initial begin
    int rn, tn, p0;
    rst = 1'b1; start = 1'b0; txin = 8'h00; rx_drv = 1'b1; loop_en = 1'b0;
    for (int i = 0; i < 10; i++) rnd[i] = 8'($urandom_range(200, 10));
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_rxout", rxout, 8'h00);
    check_eq("rst_rxdone", rxdone, 1'b0);
    check_eq("rst_txdone", txdone, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // loopback A5: latency, ordering and back-to-back period
    loop_en = 1'b1;
    txin = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    check_eq("a5_tx_fall", tx, 1'b0);
    wait_pulse(1'b1, 1500, rn);
    check_eq("a5_rx_latency", rn, RX_LAT);
    check_eq("a5_rxout", rxout, 8'hA5);
    wait_pulse(1'b0, 300, tn);
    check_eq("a5_tx_latency", rn + tn, TX_LAT);
    txin = rnd[0];
    @(negedge clk);
    check_eq("b2b_gap_high", tx, 1'b1);
    @(negedge clk);
    check_eq("b2b_restart", tx, 1'b0);

    for (int i = 0; i < 10; i++) begin
      wait_pulse(1'b1, 1500, rn);
      check_eq($sformatf("loop_byte%0d", i), rxout, rnd[i]);
      wait_pulse(1'b0, 300, tn);
      if (i < 9) txin = rnd[i + 1];
      else start = 1'b0;
    end
    repeat (5) @(negedge clk);

    // reset in the middle of the data bits
    txin = 8'h00;
    start = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_fall", tx, 1'b0);
    start = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("rst_mid_data", tx, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_tx", tx, 1'b1);
    check_eq("rst_mid_txdone", txdone, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_mid_idle", tx, 1'b1);
    txin = 8'h81;
    start = 1'b1;
    @(negedge clk);
    check_eq("fresh_fall", tx, 1'b0);
    wait_pulse(1'b1, 1500, rn);
    check_eq("fresh_rxout", rxout, 8'h81);
    wait_pulse(1'b0, 300, tn);
    start = 1'b0;
    repeat (5) @(negedge clk);

    // false start: 20-cycle low glitch
    loop_en = 1'b0;
    rx_drv = 1'b1;
    repeat (5) @(negedge clk);
    p0 = rx_pulses;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("false_start_pulses", rx_pulses - p0, 0);
    check_eq("false_start_rxout", rxout, 8'h81);

    // externally driven good frame, then 3C with a low stop bit
    p0 = rx_pulses;
    send_bits(frame_of(8'h5A, 1'b1), FRAME_BITS, C);
    check_eq("ext_good_pulses", rx_pulses - p0, 1);
    check_eq("ext_good_rxout", rxout, 8'h5A);
    p0 = rx_pulses;
    send_bits(frame_of(8'h3C, 1'b0), FRAME_BITS, 78);
    repeat (200) @(negedge clk);
    check_eq("frame_err_pulses", rx_pulses - p0, 0);
    check_eq("frame_err_rxout", rxout, 8'h5A);

`ifdef UART_PARITY_EN
    loop_en = 1'b1;
    txin = 8'h07;
    start = 1'b1;
    @(negedge clk);
    check_eq("par_fall", tx, 1'b0);
    start = 1'b0;
    repeat (9 * C + 52) @(negedge clk);
    check_eq("par_bit", tx, 1'b1);
    wait_pulse(1'b1, 500, rn);
    check_eq("par_rxout", rxout, 8'h07);
    wait_pulse(1'b0, 300, tn);
    repeat (5) @(negedge clk);
    loop_en = 1'b0;
    rx_drv = 1'b1;
    p0 = rx_pulses;
    send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11, C);
    check_eq("par_flip_pulses", rx_pulses - p0, 0);
    check_eq("par_flip_rxout", rxout, 8'h07);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
